// File: rtl/uart_tx_frame.sv
// Buffered UART transmitter: input FIFO, 16x oversampled bit timing, LSB-first frames.
// The optional parity bit is compiled in when the macro UART_TX_PARITY_EN is defined.
module uart_tx_frame #(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DIV_W-1:0]             div_i,
  input  logic [1:0]                   parity_i,
  input  logic                         stop2_i,
  input  logic [DATA_W-1:0]            data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [$clog2(FIFO_DEPTH):0]  level_o,
  output logic                         busy_o,
  output logic                         tx_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg;

  state_t            state_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DIV_W-1:0]  div_reg, div_cnt_reg;
  logic [4:0]        smp_cnt_reg;
  logic [3:0]        bit_cnt_reg;
  logic              stop2_reg;
  logic              tx_reg;

  logic push, pop, ready, tick, bit_end;
  logic [DATA_W-1:0] head;

`ifdef UART_TX_PARITY_EN
  logic [DATA_W-1:0] data_reg;
  logic [1:0]        par_reg;
  logic              par_on, par_bit;
  assign par_on  = (par_reg == 2'b01) || (par_reg == 2'b10);
  assign par_bit = (^data_reg) ^ par_reg[1];
`else
  logic unused_parity;
  assign unused_parity = ^parity_i;
`endif

  // A full FIFO refuses writes even when a pop happens on the same edge.
  assign ready = (level_reg != LVL_W'(FIFO_DEPTH));
  assign push  = valid_i && ready;
  assign head  = mem[rd_ptr_reg];

  always_comb begin
    tick    = (div_cnt_reg == div_reg);
    bit_end = tick && (smp_cnt_reg[3:0] == 4'hF) &&
              ((state_reg != S_STOP) || !stop2_reg || smp_cnt_reg[4]);
    pop     = (level_reg != '0) &&
              ((state_reg == S_IDLE) || ((state_reg == S_STOP) && bit_end));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_reg + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= S_IDLE;
      shift_reg   <= '0;
      div_reg     <= '0;
      div_cnt_reg <= '0;
      smp_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      stop2_reg   <= 1'b0;
      tx_reg      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      data_reg    <= '0;
      par_reg     <= '0;
`endif
    end else begin
      if ((state_reg == S_IDLE) || tick) div_cnt_reg <= '0;
      else                              div_cnt_reg <= div_cnt_reg + 1'b1;

      if ((state_reg != S_IDLE) && tick) smp_cnt_reg <= bit_end ? 5'd0 : smp_cnt_reg + 5'd1;

      // Every frame runs on the settings captured when its word was popped.
      if (pop) begin
        state_reg   <= S_START;
        tx_reg      <= 1'b0;
        shift_reg   <= head;
        div_reg     <= div_i;
        stop2_reg   <= stop2_i;
        div_cnt_reg <= '0;
        smp_cnt_reg <= '0;
        bit_cnt_reg <= '0;
`ifdef UART_TX_PARITY_EN
        data_reg    <= head;
        par_reg     <= parity_i;
`endif
      end else if (bit_end) begin
        case (state_reg)
          S_START: begin
            state_reg   <= S_DATA;
            tx_reg      <= shift_reg[0];
            bit_cnt_reg <= '0;
          end
          S_DATA: begin
            shift_reg <= shift_reg >> 1;
            if (bit_cnt_reg == 4'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
              if (par_on) begin
                state_reg <= S_PARITY;
                tx_reg    <= par_bit;
              end else begin
                state_reg <= S_STOP;
                tx_reg    <= 1'b1;
              end
`else
              state_reg <= S_STOP;
              tx_reg    <= 1'b1;
`endif
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              tx_reg      <= shift_reg[1];
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            state_reg <= S_STOP;
            tx_reg    <= 1'b1;
          end
`endif
          S_STOP: begin
            state_reg <= S_IDLE;
            tx_reg    <= 1'b1;
          end
          default: begin
            state_reg <= state_reg;
          end
        endcase
      end
    end
  end

  assign ready_o = ready;
  assign level_o = level_reg;
  assign busy_o  = (state_reg != S_IDLE) || (level_reg != '0);
  assign tx_o    = tx_reg;
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised, buffered UART transmitter for the MMIO trace path. It is the successor to the fixed 8N1 transmitter and adds configurable data width, runtime parity and stop-bit selection, and an input FIFO with a valid/ready handshake, so trace logic can burst bytes without polling. It shifts frames LSB-first on `tx_o` at a 16× oversampled bit rate derived from `div_i`.

## Interface
Parameters:
- `DATA_W`: default 8. Data bits per frame, legal 5..9.
- `DIV_W`: default 11. Width of the sample divider.
- `FIFO_DEPTH`: default 4. Input FIFO entries; a power of two, at least 2.

Ports:
- `clk_i` in 1: single clock. The reset is synchronous and active-high.
- `rst_i` in 1: synchronous, active-high reset.
- `div_i` in `DIV_W`: sample period minus one. One sample lasts `div_i+1` clocks.
- `parity_i` in 2: parity mode. 00 = none, 01 = even, 10 = odd, 11 = none.
- `stop2_i` in 1: 0 selects 1 stop bit, 1 selects 2 stop bits.
- `data_i` in `DATA_W`: write data.
- `valid_i` in 1: write request.
- `ready_o` out 1: FIFO not full. Reset value 1.
- `level_o` out `$clog2(FIFO_DEPTH)+1`: FIFO occupancy. Reset value 0.
- `busy_o` out 1: high when the FSM is not in Idle or the FIFO is not empty. Reset value 0.
- `tx_o` out 1: serial line, registered. Reset value 1.

## Operation
- **Write:** the FIFO accepts `data_i` on any edge where `valid_i && ready_o`. `ready_o` depends only on `level_o != FIFO_DEPTH`, so a write to a full FIFO is refused even if a pop happens on the same edge. A simultaneous push and pop on a non-full, non-empty FIFO leaves `level_o` unchanged.
- **Frame latch:** on every pop, the FSM latches the data word, `div_i`, `parity_i` and `stop2_i`. Changing any of these inputs mid-frame has no effect on the frame in progress.
- **FSM states:**
  - Idle: `tx_o`=1. If the FIFO is non-empty, pop the head and go to Start.
  - Start: `tx_o`=0 for 16 samples, then go to Data with `bit_cnt`=0.
  - Data: `tx_o`=`shift[0]` for 16 samples, then shift right. After bit `DATA_W-1`, go to Parity if parity is enabled, otherwise go to Stop.
  - Parity: `tx_o` is the XOR of the latched data (even mode), or its inverse (odd mode), for 16 samples. Then go to Stop.
  - Stop: `tx_o`=1 for 16 samples, or 32 if `stop2` is set. When Stop ends with the FIFO non-empty, pop and go directly to Start. Otherwise go to Idle.
- **Divider:** held at 0 in Idle and cleared on every pop. It counts 0..`div_i_latched`, and the sample tick fires when count equals the latched value. The sample counter is 4 bits and wraps 15→0 at the end of each bit. Stop uses a 5-bit count when `stop2` is set.
- **Outputs:** `tx_o` is driven from the `tx_next` register, so it changes on the same edge as the state register.
- **Reset:** `rst_i` asserted at any point, including mid-frame, flushes the FIFO and returns the FSM to Idle. On the next edge, `tx_o` is 1 and `ready_o` is 1.

## Timing
- Bit period is exactly `16*(div_i+1)` clocks.
- A frame lasts `(1 + DATA_W + P + S) * 16*(div_i+1)` clocks, where P is 0 or 1 (parity bit) and S is 1 or 2 (stop bits).
- Latency: a write accepted at edge E into an empty FIFO with the FSM in Idle is popped at E+1. `tx_o` falls at E+1.
- Back-to-back frames have zero idle clocks between the last stop bit and the next start bit.
- `level_o` and `ready_o` update on the push or pop edge.
- `busy_o` is combinational from registered state.

## Configuration
- **`UART_TX_PARITY_EN` defined:** the Parity state and parity logic are compiled in, and `parity_i` behaves as above.
- **`UART_TX_PARITY_EN` undefined:** the Parity state is absent and `parity_i` is ignored. Every frame has no parity bit, and Data transitions straight to Stop.

## Test plan
- **8N1 single byte:** `DATA_W`=8, `div_i`=0, parity 00, stop2=0, write 0x55. Required: `tx_o` low at E+1, then bits 1,0,1,0,1,0,1,0 at 16 clocks each, then high. Frame is 160 clocks. `busy_o` drops on the final edge.
- **Parity modes** (`UART_TX_PARITY_EN`): `div_i`=1. Write 0x07 in even mode; required parity bit 1 and frame length 11×32=352 clocks. Write 0x07 in odd mode; required parity bit 0.
- **FIFO full:** `FIFO_DEPTH`=4 with `valid_i` held high for 6 clocks. Required: 1 pop plus 4 stored entries, `ready_o`=0 afterwards, `level_o`=4. The 6th word is dropped. Five frames follow with no idle gap between them.
- **Two stop bits, 7 data bits:** `DATA_W`=7, stop2=1, write 0x7F, `div_i`=2. Required: stop high for 96 clocks, frame 10×48=480 clocks. A `div_i` change during the frame leaves the frame length unchanged.
- **Reset mid-frame:** assert `rst_i` during the Data state with 3 words queued. Required: next edge gives `tx_o`=1, `level_o`=0, `ready_o`=1, `busy_o`=0. No further start bit appears until a new write.
